// File: rtl/wb_writer_pkg.sv
// Shared defines for the write-back path.
//   RegBus / RegAddrBus / RegNum : integer register file geometry
//   WbDepth                      : default load-queue depth for wb_writer
//   wb_src_e                     : which source owns the regfile write port this cycle
package wb_writer_pkg;

  localparam int unsigned RegBus     = 32;
  localparam int unsigned RegAddrBus = 5;
  localparam int unsigned RegNum     = 32;
  localparam int unsigned WbDepth    = 4;

  typedef enum logic [1:0] {
    WB_SRC_NONE   = 2'd0,
    WB_SRC_ALU    = 2'd1,
    WB_SRC_QUEUE  = 2'd2,
    WB_SRC_BYPASS = 2'd3
  } wb_src_e;

endpackage

// File: rtl/wb_writer_fifo.sv
// wb_fifo: load queue for the write-back writer.
// Holds {live, rd, data} entries in FIFO order with a count register, clears the
// live bit of every entry matching a kill address, and reports whether any live
// entry targets either decode lookup index.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   push, push_rd/_data    enqueue request (ignored when full)
//   pop                    dequeue head (ignored when empty)
//   kill_en, kill_rd       clear live on all entries with rd == kill_rd
//   raddr1/2, pend1_c/2_c  pending-write lookup
//   full_c, empty_c        from the registered count
//   head_live_c/rd_c/data_c  current head entry
module wb_fifo
  import wb_writer_pkg::*;
#(
  parameter int unsigned DEPTH  = WbDepth,
  parameter int unsigned DATA_W = RegBus,
  parameter int unsigned ADDR_W = RegAddrBus
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_rd,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              kill_en,
  input  logic [ADDR_W-1:0] kill_rd,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic              pend1_c,
  output logic              pend2_c,
  output logic              full_c,
  output logic              empty_c,
  output logic              head_live_c,
  output logic [ADDR_W-1:0] head_rd_c,
  output logic [DATA_W-1:0] head_data_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DEPTH-1:0]  live_q, live_d;
  logic [ADDR_W-1:0] mem_rd_q   [DEPTH];
  logic [ADDR_W-1:0] mem_rd_d   [DEPTH];
  logic [DATA_W-1:0] mem_data_q [DEPTH];
  logic [DATA_W-1:0] mem_data_d [DEPTH];

  logic push_ok, pop_ok;
  logic hit1, hit2;

  assign full_c  = (count_q == CNT_W'(DEPTH));
  assign empty_c = (count_q == '0);
  assign push_ok = push && !full_c;
  assign pop_ok  = pop && !empty_c;

  assign head_live_c = live_q[rd_ptr_q];
  assign head_rd_c   = mem_rd_q[rd_ptr_q];
  assign head_data_c = mem_data_q[rd_ptr_q];

  // Next-state for pointers, count, live bits and storage.
  // Kill first, then pop: a popped entry leaves dead regardless of a kill.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    live_d     = live_q;
    mem_rd_d   = mem_rd_q;
    mem_data_d = mem_data_q;

    if (kill_en) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (mem_rd_q[i] == kill_rd) live_d[i] = 1'b0;
      end
    end

    if (pop_ok) begin
      live_d[rd_ptr_q] = 1'b0;
      rd_ptr_d         = rd_ptr_q + PTR_W'(1);
    end

    if (push_ok) begin
      live_d[wr_ptr_q]     = 1'b1;
      mem_rd_d[wr_ptr_q]   = push_rd;
      mem_data_d[wr_ptr_q] = push_data;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end

    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Live bits are cleared on pop, so live implies occupied.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_q[i] && (mem_rd_q[i] == raddr1)) hit1 = 1'b1;
      if (live_q[i] && (mem_rd_q[i] == raddr2)) hit2 = 1'b1;
    end
    pend1_c = hit1 && (raddr1 != '0);
    pend2_c = hit2 && (raddr2 != '0);
  end

  // Control state.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      live_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      live_q   <= live_d;
    end
  end

  // Payload storage; validity is carried by live_q, so no reset needed.
  always_ff @(posedge clk) begin
    mem_rd_q   <= mem_rd_d;
    mem_data_q <= mem_data_d;
  end

endmodule

// File: rtl/wb_writer.sv
// wb_writer: drives the integer regfile write port.
// Merges single-cycle ALU results with queued load results, one commit per
// cycle, ALU first. Loads are buffered in wb_fifo; an ALU write kills older
// queued loads to the same register.
// Optional build macro: WB_BYPASS_EN -- a load arriving with the queue empty and
// no ALU result is written straight to the output registers.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   alu_valid/alu_rd/alu_data        ALU result, always accepted
//   ld_valid/ld_rd/ld_data/ld_ready  load result handshake
//   stall_req                        queue full
//   raddr1/2, pend1/2                pending-write lookup for decode
//   we/waddr/wdata                   registered regfile write port
module wb_writer
  import wb_writer_pkg::*;
#(
  parameter int unsigned DEPTH  = WbDepth,
  parameter int unsigned DATA_W = RegBus,
  parameter int unsigned ADDR_W = RegAddrBus
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_rd,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              stall_req,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic              pend1,
  output logic              pend2,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata
);

  logic              alu_ok;
  logic              ld_fire;
  logic              ld_keep;
  logic              bypass;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic              head_live;
  logic [ADDR_W-1:0] head_rd;
  logic [DATA_W-1:0] head_data;
  wb_src_e           src;

  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  // Writes to x0 are dropped; a load to x0 still completes its handshake.
  assign alu_ok  = alu_valid && (alu_rd != '0);
  assign ld_fire = ld_valid && ld_ready;
  // A same-cycle ALU write to the same rd is younger, so the load is discarded.
  assign ld_keep = ld_fire && (ld_rd != '0) && !(alu_ok && (ld_rd == alu_rd));

`ifdef WB_BYPASS_EN
  assign bypass = ld_keep && fifo_empty && !alu_valid;
`else
  assign bypass = 1'b0;
`endif

  assign fifo_push = ld_keep && !bypass;
  // Head pops (live or dead) whenever no ALU result claims the port.
  assign fifo_pop  = !alu_ok && !fifo_empty;

  // ready/stall come from the registered count, so a pop never frees a slot early.
  assign ld_ready  = !fifo_full;
  assign stall_req = fifo_full;

  wb_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (fifo_push),
    .push_rd     (ld_rd),
    .push_data   (ld_data),
    .pop         (fifo_pop),
    .kill_en     (alu_ok),
    .kill_rd     (alu_rd),
    .raddr1      (raddr1),
    .raddr2      (raddr2),
    .pend1_c     (pend1),
    .pend2_c     (pend2),
    .full_c      (fifo_full),
    .empty_c     (fifo_empty),
    .head_live_c (head_live),
    .head_rd_c   (head_rd),
    .head_data_c (head_data)
  );

  // Commit source priority: ALU, then queue head, then bypassed load.
  always_comb begin
    src = WB_SRC_NONE;
    if (alu_ok)        src = WB_SRC_ALU;
    else if (fifo_pop) src = WB_SRC_QUEUE;
    else if (bypass)   src = WB_SRC_BYPASS;
  end

  // Output register next-state; idle cycles and dead pops write zeros with we=0.
  always_comb begin
    we_d    = 1'b0;
    waddr_d = '0;
    wdata_d = '0;
    case (src)
      WB_SRC_ALU: begin
        we_d    = 1'b1;
        waddr_d = alu_rd;
        wdata_d = alu_data;
      end
      WB_SRC_QUEUE: begin
        if (head_live) begin
          we_d    = 1'b1;
          waddr_d = head_rd;
          wdata_d = head_data;
        end
      end
      WB_SRC_BYPASS: begin
        we_d    = 1'b1;
        waddr_d = ld_rd;
        wdata_d = ld_data;
      end
      default: begin
        we_d = 1'b0;
      end
    endcase
  end

  // Regfile write port registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign we    = we_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;

endmodule

// File: tb/tb_wb_writer.sv
// Testbench for wb_writer: directed vector table, hand-written latency and reset
// sequences, then randomized traffic against a queue-based reference model.
module tb_wb_writer;

  localparam int unsigned DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic        stall_req;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic        pend1;
  logic        pend2;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;

  int n_checks;
  int n_errors;

  logic act_rdy, act_p1, act_p2;

  wb_writer #(
    .DEPTH  (DEPTH),
    .DATA_W (32),
    .ADDR_W (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .ld_valid  (ld_valid),
    .ld_rd     (ld_rd),
    .ld_data   (ld_data),
    .ld_ready  (ld_ready),
    .stall_req (stall_req),
    .raddr1    (raddr1),
    .raddr2    (raddr2),
    .pend1     (pend1),
    .pend2     (pend2),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: a queue of pending loads plus the expected write port.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    bit          live;
  } ent_t;

  ent_t        mq[$];
  bit          m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;

  function automatic bit m_pend(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    foreach (mq[i]) if (mq[i].live && mq[i].rd == a) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_edge(input logic r, input logic av, input logic [4:0] ard,
                            input logic [31:0] ad, input logic lv, input logic [4:0] lrd,
                            input logic [31:0] ld);
    bit   ready, acc, alu_ok, was_empty, keep;
    ent_t e;
    if (r) begin
      mq.delete();
      m_we = 0; m_waddr = '0; m_wdata = '0;
      return;
    end
    ready     = (mq.size() < DEPTH);
    acc       = lv && ready;
    alu_ok    = av && (ard != 5'd0);
    was_empty = (mq.size() == 0);
    keep      = acc && (lrd != 5'd0) && !(alu_ok && lrd == ard);
    m_we = 0; m_waddr = '0; m_wdata = '0;
    if (alu_ok) begin
      m_we = 1; m_waddr = ard; m_wdata = ad;
      foreach (mq[i]) if (mq[i].rd == ard) mq[i].live = 1'b0;
    end else if (!was_empty) begin
      e = mq.pop_front();
      if (e.live) begin
        m_we = 1; m_waddr = e.rd; m_wdata = e.data;
      end
    end
`ifdef WB_BYPASS_EN
    if (keep && was_empty && !av) begin
      m_we = 1; m_waddr = lrd; m_wdata = ld;
      keep = 0;
    end
`endif
    if (keep) begin
      e.rd = lrd; e.data = ld; e.live = 1'b1;
      mq.push_back(e);
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, check combinational outputs, advance model, check registers.
  task automatic step(input logic r, input logic av, input logic [4:0] ard,
                      input logic [31:0] ad, input logic lv, input logic [4:0] lrd,
                      input logic [31:0] ld, input logic [4:0] r1, input logic [4:0] r2);
    rst = r; alu_valid = av; alu_rd = ard; alu_data = ad;
    ld_valid = lv; ld_rd = lrd; ld_data = ld; raddr1 = r1; raddr2 = r2;
    @(negedge clk);
    act_rdy = ld_ready; act_p1 = pend1; act_p2 = pend2;
    chk("model_ld_ready", 32'(ld_ready), 32'(mq.size() < DEPTH));
    chk("model_stall_req", 32'(stall_req), 32'(mq.size() >= DEPTH));
    chk("model_pend1", 32'(pend1), 32'(m_pend(r1)));
    chk("model_pend2", 32'(pend2), 32'(m_pend(r2)));
    model_edge(r, av, ard, ad, lv, lrd, ld);
    @(posedge clk);
    #1;
    chk("model_we", 32'(we), 32'(m_we));
    chk("model_waddr", 32'(waddr), 32'(m_waddr));
    chk("model_wdata", wdata, m_wdata);
  endtask

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ld;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        e_rdy;
    logic        e_p1;
    logic        e_p2;
    logic        e_we;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
  } vec_t;

  function automatic vec_t mk(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                              input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                              input logic [4:0] r1, input logic [4:0] r2,
                              input logic e_rdy, input logic e_p1, input logic e_p2,
                              input logic e_we, input logic [4:0] e_waddr,
                              input logic [31:0] e_wdata);
    vec_t v;
    v.av = av; v.ard = ard; v.ad = ad; v.lv = lv; v.lrd = lrd; v.ld = ld;
    v.r1 = r1; v.r2 = r2; v.e_rdy = e_rdy; v.e_p1 = e_p1; v.e_p2 = e_p2;
    v.e_we = e_we; v.e_waddr = e_waddr; v.e_wdata = e_wdata;
    return v;
  endfunction

  vec_t vt[21];

  initial begin
    n_checks = 0;
    n_errors = 0;

    //        av ard    ad            lv lrd    ld            r1     r2     rdy p1 p2 we waddr  wdata
    vt[0]  = mk(1, 5'd5,  32'h11112222, 0, 5'd0,  32'h0,        5'd0,  5'd0,  1, 0, 0, 1, 5'd5,  32'h11112222);
    vt[1]  = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        5'd0,  5'd0,  1, 0, 0, 0, 5'd0,  32'h0);
    vt[2]  = mk(1, 5'd9,  32'h1,        1, 5'd9,  32'h2,        5'd0,  5'd0,  1, 0, 0, 1, 5'd9,  32'h1);
    vt[3]  = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        5'd9,  5'd0,  1, 0, 0, 0, 5'd0,  32'h0);
    vt[4]  = mk(1, 5'd0,  32'h55,       1, 5'd0,  32'h66,       5'd0,  5'd0,  1, 0, 0, 0, 5'd0,  32'h0);
    vt[5]  = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        5'd0,  5'd0,  1, 0, 0, 0, 5'd0,  32'h0);
    vt[6]  = mk(1, 5'd1,  32'h100,      1, 5'd3,  32'hA,        5'd3,  5'd0,  1, 0, 0, 1, 5'd1,  32'h100);
    vt[7]  = mk(1, 5'd3,  32'hB,        0, 5'd0,  32'h0,        5'd3,  5'd0,  1, 1, 0, 1, 5'd3,  32'hB);
    vt[8]  = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        5'd3,  5'd0,  1, 0, 0, 0, 5'd0,  32'h0);
    vt[9]  = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        5'd3,  5'd0,  1, 0, 0, 0, 5'd0,  32'h0);
    vt[10] = mk(1, 5'd2,  32'h20,       1, 5'd10, 32'h1000,     5'd0,  5'd0,  1, 0, 0, 1, 5'd2,  32'h20);
    vt[11] = mk(1, 5'd2,  32'h21,       1, 5'd11, 32'h1001,     5'd0,  5'd0,  1, 0, 0, 1, 5'd2,  32'h21);
    vt[12] = mk(1, 5'd2,  32'h22,       1, 5'd12, 32'h1002,     5'd0,  5'd10, 1, 0, 1, 1, 5'd2,  32'h22);
    vt[13] = mk(1, 5'd2,  32'h23,       1, 5'd13, 32'h1003,     5'd0,  5'd0,  1, 0, 0, 1, 5'd2,  32'h23);
    vt[14] = mk(1, 5'd2,  32'h24,       1, 5'd14, 32'h1004,     5'd0,  5'd0,  0, 0, 0, 1, 5'd2,  32'h24);
    vt[15] = mk(0, 5'd0,  32'h0,        1, 5'd14, 32'h1004,     5'd13, 5'd0,  0, 1, 0, 1, 5'd10, 32'h1000);
    vt[16] = mk(0, 5'd0,  32'h0,        1, 5'd14, 32'h1004,     5'd0,  5'd0,  1, 0, 0, 1, 5'd11, 32'h1001);
    vt[17] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        5'd0,  5'd0,  1, 0, 0, 1, 5'd12, 32'h1002);
    vt[18] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        5'd0,  5'd0,  1, 0, 0, 1, 5'd13, 32'h1003);
    vt[19] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        5'd0,  5'd0,  1, 0, 0, 1, 5'd14, 32'h1004);
    vt[20] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        5'd0,  5'd0,  1, 0, 0, 0, 5'd0,  32'h0);

    rst = 1'b1; alu_valid = 0; alu_rd = '0; alu_data = '0;
    ld_valid = 0; ld_rd = '0; ld_data = '0; raddr1 = '0; raddr2 = '0;
    @(posedge clk);
    #1;
    step(1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd0, 5'd0);
    chk("reset_we", 32'(we), 32'd0);
    chk("reset_waddr", 32'(waddr), 32'd0);
    chk("reset_wdata", wdata, 32'd0);

    // Directed vector table.
    for (int i = 0; i < 21; i++) begin
      step(0, vt[i].av, vt[i].ard, vt[i].ad, vt[i].lv, vt[i].lrd, vt[i].ld, vt[i].r1, vt[i].r2);
      chk($sformatf("vec%0d_ld_ready", i), 32'(act_rdy), 32'(vt[i].e_rdy));
      chk($sformatf("vec%0d_stall", i), 32'(!act_rdy), 32'(!vt[i].e_rdy));
      chk($sformatf("vec%0d_pend1", i), 32'(act_p1), 32'(vt[i].e_p1));
      chk($sformatf("vec%0d_pend2", i), 32'(act_p2), 32'(vt[i].e_p2));
      chk($sformatf("vec%0d_we", i), 32'(we), 32'(vt[i].e_we));
      chk($sformatf("vec%0d_waddr", i), 32'(waddr), 32'(vt[i].e_waddr));
      chk($sformatf("vec%0d_wdata", i), wdata, vt[i].e_wdata);
    end

    // Load latency with an empty queue and idle ALU.
    step(0, 0, 5'd0, 32'h0, 1, 5'd7, 32'hDEADBEEF, 5'd0, 5'd0);
`ifdef WB_BYPASS_EN
    chk("load_lat_n1_we", 32'(we), 32'd1);
    chk("load_lat_n1_waddr", 32'(waddr), 32'd7);
    chk("load_lat_n1_wdata", wdata, 32'hDEADBEEF);
    step(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd0, 5'd0);
    chk("load_lat_n2_we", 32'(we), 32'd0);
`else
    chk("load_lat_n1_we", 32'(we), 32'd0);
    step(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd7, 5'd0);
    chk("load_lat_n2_we", 32'(we), 32'd1);
    chk("load_lat_n2_waddr", 32'(waddr), 32'd7);
    chk("load_lat_n2_wdata", wdata, 32'hDEADBEEF);
`endif

    // Reset mid-drain: queue three loads behind a busy ALU, then reset.
    step(0, 1, 5'd1, 32'h1, 1, 5'd20, 32'h200, 5'd0, 5'd0);
    step(0, 1, 5'd1, 32'h2, 1, 5'd21, 32'h201, 5'd0, 5'd0);
    step(0, 1, 5'd1, 32'h3, 1, 5'd22, 32'h202, 5'd20, 5'd0);
    step(1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd20, 5'd0);
    chk("rst_mid_pend_before", 32'(act_p1), 32'd1);
    chk("rst_mid_we", 32'(we), 32'd0);
    chk("rst_mid_waddr", 32'(waddr), 32'd0);
    chk("rst_mid_wdata", wdata, 32'd0);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd20, 5'd21);
      chk("rst_after_ld_ready", 32'(act_rdy), 32'd1);
      chk("rst_after_pend1", 32'(act_p1), 32'd0);
      chk("rst_after_pend2", 32'(act_p2), 32'd0);
      chk("rst_after_we", 32'(we), 32'd0);
    end

    // Randomized traffic against the reference model.
    for (int k = 0; k < 600; k++) begin
      step(($urandom_range(0, 79) == 0),
           1'($urandom_range(0, 99) < 40),
           5'($urandom_range(0, 7)),
           $urandom,
           1'($urandom_range(0, 99) < 60),
           5'($urandom_range(0, 7)),
           $urandom,
           5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
